// File: rtl/gcd_fsmd_param.sv
// gcd_fsmd_param: GCD of two unsigned WIDTH-bit operands by repeated subtraction.
// The controller and datapath are merged into one block. Start and finish use a
// four-phase go/done handshake. Zero operands are detected, subtraction steps
// are counted, and a watchdog aborts a run that exceeds MAX_ITER steps.
module gcd_fsmd_param #(
  parameter int WIDTH    = 8,
  parameter int MAX_ITER = 2**WIDTH,
  parameter int CNT_W    = WIDTH + 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             go_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] d_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] iter_o
);

  localparam logic [CNT_W-1:0] ITER_LIM = CNT_W'(MAX_ITER);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] x_q, y_q, x_nx, y_nx, d_nx;
  logic [CNT_W-1:0] iter_nx;
  logic             err_nx;

  // Next state and next datapath values; every register holds unless a branch
  // says otherwise.
  always_comb begin
    state_nx = state;
    x_nx     = x_q;
    y_nx     = y_q;
    d_nx     = d_o;
    err_nx   = err_o;
    iter_nx  = iter_o;
    case (state)
      IDLE: begin
        if (go_i) begin
          x_nx     = x_i;
          y_nx     = y_i;
          iter_nx  = '0;
          err_nx   = 1'b0;
          state_nx = CALC;
        end
      end
      CALC: begin
        if (!go_i) begin
          // Abort: result and error flag stay as they were before the run.
          state_nx = IDLE;
        end else if (x_q == '0 || y_q == '0) begin
          d_nx     = x_q | y_q;
          err_nx   = (x_q == '0) && (y_q == '0);
          state_nx = DONE;
        end else if (x_q == y_q) begin
          d_nx     = x_q;
          err_nx   = 1'b0;
          state_nx = DONE;
        end else if (iter_o == ITER_LIM) begin
          d_nx     = '0;
          err_nx   = 1'b1;
          state_nx = DONE;
        end else if (x_q < y_q) begin
          y_nx     = y_q - x_q;
          iter_nx  = iter_o + 1'b1;
        end else begin
          x_nx     = x_q - y_q;
          iter_nx  = iter_o + 1'b1;
        end
      end
      DONE: begin
        // Leaving DONE needs go low; go held high never restarts a run.
        if (!go_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers. done/busy are flops loaded from the next
  // state so they track the state register exactly, with no decode glitches.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      d_o    <= '0;
      err_o  <= 1'b0;
      iter_o <= '0;
      done_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state  <= state_nx;
      x_q    <= x_nx;
      y_q    <= y_nx;
      d_o    <= d_nx;
      err_o  <= err_nx;
      iter_o <= iter_nx;
      done_o <= (state_nx == DONE);
      busy_o <= (state_nx == CALC);
    end
  end

endmodule

// File: doc/gcd_fsmd_param.md
Name: gcd_fsmd_param

Overview:
Parametrised, self-contained GCD engine that merges controller and datapath into one block. It computes the GCD of two unsigned WIDTH-bit operands by repeated subtraction. Start and finish use a four-phase go/done handshake. It adds zero-operand handling, an iteration counter and a watchdog timeout. It sits as a leaf accelerator under the lab top level, driven by switch and register inputs.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
MAX_ITER, 2**WIDTH, maximum subtraction steps before the timeout error
CNT_W, WIDTH+1, iteration counter width; must hold MAX_ITER

Ports:
CLK  in  1  rising-edge clock
RESET_N  in  1  asynchronous active-low reset
go_i  in  1  start request; level, four-phase
x_i  in  WIDTH  operand X, sampled on the start edge
y_i  in  WIDTH  operand Y, sampled on the start edge
d_o  out  WIDTH  GCD result, registered
done_o  out  1  result valid; high while in DONE
busy_o  out  1  high while in CALC
err_o  out  1  both operands zero, or timeout; valid with done_o
iter_o  out  CNT_W  subtraction steps used in the last/current run

Behaviour:
- Single clock CLK. Reset is asynchronous and active-low on RESET_N.
- Reset: state=IDLE; X, Y, d_o, iter_o, err_o = 0; done_o = busy_o = 0. Reset asserted at any point, including mid-CALC, aborts immediately.
- States: IDLE, CALC, DONE. done_o = (state==DONE) and busy_o = (state==CALC), decoded from the state register with no glitch paths.
- IDLE:
  - go_i=1 at an edge: X<=x_i, Y<=y_i, iter_o<=0, err_o<=0, go to CALC.
  - d_o holds its previous value.
- CALC: one decision per cycle, evaluated in priority order:
  1. go_i=0: abort. Go to IDLE; d_o and err_o unchanged; done_o never asserts.
  2. X==0 or Y==0: d_o<=X|Y, err_o<=(X==0 && Y==0), go to DONE.
  3. X==Y: d_o<=X, err_o<=0, go to DONE.
  4. iter_o==MAX_ITER: d_o<=0, err_o<=1, go to DONE (timeout).
  5. X<Y: Y<=Y-X, iter_o<=iter_o+1, stay in CALC.
  6. X>Y: X<=X-Y, iter_o<=iter_o+1, stay in CALC.
- Arithmetic:
  - Subtraction is unsigned WIDTH-bit; it cannot underflow because the larger operand is always the minuend.
  - The comparator is a full WIDTH-bit unsigned compare.
- DONE:
  - d_o, err_o and iter_o hold; done_o=1.
  - Stay while go_i=1. go_i=0 at an edge returns to IDLE, so done_o drops the following cycle.
  - A new start needs go_i to be seen low, then high (four-phase). go_i held high through DONE never restarts.
- Latency: start edge at k, then N subtractions, then done_o is high after edge k+1+N. Equal or zero operands finish at k+1.
- Worst case without timeout: gcd(2**WIDTH-1, 1) = 2**WIDTH-2 steps. The MAX_ITER default never triggers for legal operands.
- x_i and y_i are ignored outside the start edge. Changes during CALC have no effect.

Test Plan:
1. WIDTH=8. Reset, then go_i=1 with x_i=12, y_i=8 held.
   - Required: busy_o for 3 cycles; done_o high after edge k+3.
   - Required: d_o=4, iter_o=2, err_o=0.
   - Then go_i=0: done_o low 1 cycle later; d_o still 4.
2. Zero and equal operands:
   - (0,9): d_o=9, err_o=0, done after 1 cycle, iter_o=0.
   - (0,0): d_o=0, err_o=1.
   - (255,255): d_o=255, iter_o=0.
3. Bounds, WIDTH=8, (255,1): d_o=1, iter_o=254, err_o=0, done_o at edge k+255.
4. Abort and restart:
   - go_i dropped 2 cycles into CALC for (200,3): returns to IDLE, done_o stays 0, d_o keeps its prior value.
   - Re-go with (18,24): d_o=6, iter_o=3.
5. Timeout, MAX_ITER=4, (20,3): after 4 steps X=8, Y=3, timeout fires; d_o=0, err_o=1, iter_o=4, done_o high after edge k+5.
6. Reset mid-CALC: RESET_N low asynchronously during (255,1). Required: all outputs 0 immediately, without waiting for a clock edge; state IDLE after release; go_i held high restarts cleanly.
